// File: rtl/disp_mux_n.sv
// Time-multiplexed common-anode seven-segment driver for up to eight digits.
// Hex-decode or raw-pattern modes, per-digit blank and dp, dead time and PWM dimming.
module disp_mux_n #(
    parameter int N_DIGITS    = 8,
    parameter int SLOT_CYCLES = 100000,
    parameter int DEAD_CYCLES = 2,
    parameter int DIM_BITS    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  mode,
    input  logic [4*N_DIGITS-1:0] hex,
    input  logic [8*N_DIGITS-1:0] raw,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic [N_DIGITS-1:0]   blank,
    input  logic [DIM_BITS-1:0]   brightness,
    output logic [7:0]            an,
    output logic [7:0]            sseg,
    output logic [2:0]            digit_idx,
    output logic                  frame_tick
);

    localparam int                  CNT_W    = $clog2(SLOT_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0]    CNT_DEAD = CNT_W'(DEAD_CYCLES);
    localparam logic [2:0]          IDX_LAST = 3'(N_DIGITS - 1);
    localparam logic [DIM_BITS-1:0] DIM_FULL = {DIM_BITS{1'b1}};

    // Active-low {dp,g,f,e,d,c,b,a} glyphs, decimal point off.
    function automatic logic [7:0] hex_to_sseg(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0:    s = 8'hC0;
            4'h1:    s = 8'hF9;
            4'h2:    s = 8'hA4;
            4'h3:    s = 8'hB0;
            4'h4:    s = 8'h99;
            4'h5:    s = 8'h92;
            4'h6:    s = 8'h82;
            4'h7:    s = 8'hF8;
            4'h8:    s = 8'h80;
            4'h9:    s = 8'h90;
            4'hA:    s = 8'h88;
            4'hB:    s = 8'h83;
            4'hC:    s = 8'hC6;
            4'hD:    s = 8'hA1;
            4'hE:    s = 8'h86;
            4'hF:    s = 8'h8E;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0]    cnt_r;
    logic [2:0]          idx_r;
    logic [DIM_BITS-1:0] pwm_r;
    logic [7:0]          an_r;
    logic [7:0]          sseg_r;
    logic [2:0]          digit_idx_r;
    logic                frame_tick_r;

    logic [CNT_W-1:0]    cnt_nxt_s;
    logic [2:0]          idx_nxt_s;
    logic                cnt_wrap_s;
    logic                idx_wrap_s;
    logic [3:0]          nib_s;
    logic [7:0]          byte_s;
    logic                blank_s;
    logic                dp_s;
    logic                pwm_on_s;
    logic                en_s;
    logic [7:0]          an_s;
    logic [7:0]          sseg_s;

    // Scan sequencing and per-digit output selection from current state and live inputs.
    always_comb begin
        cnt_wrap_s = (cnt_r == CNT_LAST);
        idx_wrap_s = (idx_r == IDX_LAST);
        nib_s      = hex[{idx_r, 2'b00} +: 4];
        byte_s     = raw[{idx_r, 3'b000} +: 8];
        blank_s    = blank[idx_r];
        dp_s       = dp[idx_r];
        pwm_on_s   = (brightness == DIM_FULL) || (pwm_r < brightness);
        en_s       = (cnt_r >= CNT_DEAD) && !blank_s && pwm_on_s;

        if (cnt_wrap_s) begin
            cnt_nxt_s = {CNT_W{1'b0}};
            if (idx_wrap_s) begin
                idx_nxt_s = 3'd0;
            end else begin
                idx_nxt_s = idx_r + 3'd1;
            end
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
            idx_nxt_s = idx_r;
        end

        an_s = 8'hFF;
        if (en_s) begin
            an_s[idx_r] = 1'b0;
        end else begin
            an_s = 8'hFF;
        end

        if (blank_s) begin
            sseg_s = 8'hFF;
        end else if (mode) begin
            sseg_s = hex_to_sseg(nib_s) & {~dp_s, 7'h7F};
        end else begin
            sseg_s = byte_s;
        end
    end

    // State and output registers; reset aborts any slot in progress.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r        <= {CNT_W{1'b0}};
            idx_r        <= 3'd0;
            pwm_r        <= {DIM_BITS{1'b0}};
            an_r         <= 8'hFF;
            sseg_r       <= 8'hFF;
            digit_idx_r  <= 3'd0;
            frame_tick_r <= 1'b0;
        end else begin
            cnt_r        <= cnt_nxt_s;
            idx_r        <= idx_nxt_s;
            pwm_r        <= pwm_r + DIM_BITS'(1);
            an_r         <= an_s;
            sseg_r       <= sseg_s;
            digit_idx_r  <= idx_r;
            frame_tick_r <= cnt_wrap_s && idx_wrap_s;
        end
    end

    assign an         = an_r;
    assign sseg       = sseg_r;
    assign digit_idx  = digit_idx_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: doc/disp_mux_n.md
# disp_mux_n

Parametrised time-multiplexed seven-segment display driver for up to eight digits on the board's common-anode display. Successor to the four-digit `disp_mux`, adding:
- configurable digit count and refresh slot length;
- a selectable hex-decode or raw-pattern mode;
- per-digit blanking and decimal points;
- anti-ghosting dead time and PWM brightness control.

It sits between the user register bank (switch/button-loaded digit registers) and the `an`/`sseg` top-level pins.

## Interface

Parameters:
- `N_DIGITS`, 8, number of scanned digits, legal range 2..8.
- `SLOT_CYCLES`, 100000, clock cycles each digit is selected (1 ms at 100 MHz), minimum 4.
- `DEAD_CYCLES`, 2, cycles at the start of each slot with all anodes off, must be < `SLOT_CYCLES`.
- `DIM_BITS`, 4, width of the brightness control.

Ports:
- `clk` input 1: system clock, all logic on its rising edge.
- `reset_n` input 1: reset, synchronous and active-low.
- `mode` input 1: 0 = raw patterns from `raw`, 1 = hex decode of `hex`.
- `hex` input 4*N_DIGITS: nibble i (bits 4i+3..4i) is the hex value for digit i.
- `raw` input 8*N_DIGITS: byte i is the active-low pattern {dp,g,f,e,d,c,b,a} for digit i.
- `dp` input N_DIGITS: active-high decimal point per digit; used in hex mode only.
- `blank` input N_DIGITS: active-high per-digit blank; applies in both modes.
- `brightness` input DIM_BITS: 0 = dark, all-ones = full on.
- `an` output 8: active-low anode enables; bits N_DIGITS..7 are always 1.
- `sseg` output 8: active-low segments {dp,g,f,e,d,c,b,a}.
- `digit_idx` output 3: index of the digit currently scanned.
- `frame_tick` output 1: one-cycle pulse when the scan wraps from digit N_DIGITS-1 to 0.

## Operation

- State:
  - slot counter `cnt`, 0..SLOT_CYCLES-1;
  - digit index `idx`, 0..N_DIGITS-1;
  - free-running `pwm` counter, DIM_BITS wide, wraps naturally.
- `cnt` increments every cycle. At SLOT_CYCLES-1 it wraps to 0, and on that same edge `idx` advances.
- `idx` wraps from N_DIGITS-1 to 0. `frame_tick` is asserted for exactly the cycle following that wrap edge.
- Digit enable `en` = (cnt >= DEAD_CYCLES) AND NOT blank[idx] AND (brightness == all-ones OR pwm < brightness).
- `an` = all ones except bit idx, which is 0 when `en`.
- Segment value:
  - Hex mode: `sseg` = decode(hex[idx]) with bit 7 cleared when dp[idx].
  - Raw mode: `sseg` = raw[idx].
  - Blanked digit: `sseg` = 8'hFF.
- Hex decode (dp off): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- Inputs are sampled every cycle, not latched per slot. Changing an input mid-slot is visible on the next cycle.
- `mode` may change at any time; the change takes effect on the next registered output.

## Timing

- All outputs are registered. Outputs after edge k are a function of state and inputs before edge k; latency is one cycle.
- Reset (`reset_n` low at an edge):
  - cnt = 0, idx = 0, pwm = 0;
  - an = 8'hFF, sseg = 8'hFF, digit_idx = 0, frame_tick = 0.
- Reset asserted mid-slot or mid-frame aborts the scan immediately; no partial-slot state survives.
- After reset release, the first edge with reset_n high processes cnt = 0, which is dead time, so `an` stays 8'hFF. Digit 0 is first enabled after edge DEAD_CYCLES+1.
- `digit_idx` mirrors the registered idx; `frame_tick` is registered with the outputs.
- Frame period = N_DIGITS × SLOT_CYCLES cycles; `frame_tick` is exactly that many cycles apart.
- Brightness changes take effect on the next cycle. brightness = 0 keeps all anodes high; all-ones gives 100% duty outside dead time.

## Test plan

Bench parameters: N_DIGITS = 4, SLOT_CYCLES = 8, DEAD_CYCLES = 2, DIM_BITS = 4.

- Reset/scan: hold reset_n low 3 cycles, then release; brightness = F, mode = 1, hex = 16'h3210, no blank.
  - an = FF for 3 cycles after release, then FE with sseg = C0 for 6 cycles;
  - then FF ×2, then FD with sseg = F9;
  - frame_tick pulses every 32 cycles;
  - an[7:4] stays 1 throughout.
- Hex decode and dp: step hex[3:0] through 0..F with dp[0] = 1.
  - sseg matches the decode table with bit 7 cleared (e.g. 8 → 00, F → 0E).
- Raw and blank: mode = 0, raw = 32'hA5_5A_00_FF, blank = 4'b0100.
  - digit 1 shows 00, digit 3 shows A5;
  - during digit 2's slot an = FF and sseg = FF.
- Brightness: brightness = 4.
  - over 16 non-dead cycles, the enabled digit's anode is low in exactly 4 cycles per pwm period;
  - brightness = 0 gives an = FF permanently.
- Reset mid-frame: assert reset_n low while idx = 2 and cnt = 5.
  - the next cycle shows an = FF, digit_idx = 0;
  - the scan restarts at digit 0 with a full dead time.
